// File: rtl/axi_2to1_arbiter_pkg.sv
// Shared AXI4 channel types, arbiter FSM encodings and master indices for the
// two-master memory arbiter.
package axi_2to1_arbiter_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } arb_wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } arb_rd_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  function automatic logic [1:0] arb_onehot(input logic idx);
    if (idx == ARB_M1) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/axi_2to1_arbiter_rr.sv
// Two-way grant register with a round-robin pointer; captures a winner on
// 'advance' and releases it on 'done', handing preference to the other master.
module axi_rr_arb2
  import axi_2to1_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       done,
  output logic [1:0] gnt
);

  logic       ptr_r;
  logic [1:0] gnt_r;
  logic       win_s;

  // Winner selection: lone requester wins, conflicts go to m0 or the pointer.
  always_comb begin
    win_s = ptr_r;
    case (req)
      2'b01:   win_s = ARB_M0;
      2'b10:   win_s = ARB_M1;
      2'b11:   win_s = (FIXED_PRIO != 0) ? ARB_M0 : ptr_r;
      default: win_s = ptr_r;
    endcase
  end

  // Grant and pointer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r <= 2'b00;
      ptr_r <= ARB_M0;
    end else if (advance && (req != 2'b00)) begin
      gnt_r <= arb_onehot(win_s);
    end else if (done) begin
      gnt_r <= 2'b00;
      ptr_r <= ~gnt_r[1];
    end
  end

  assign gnt = gnt_r;

endmodule

// File: rtl/axi_2to1_arbiter.sv
// Two-master / one-slave AXI4 arbiter: independent write and read paths, one
// transaction in flight each, payloads passed straight through to the owner.
module axi_2to1_arbiter
  import axi_2to1_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  axi_req_t   m0_req_i,
  output axi_resp_t  m0_resp_o,
  input  axi_req_t   m1_req_i,
  output axi_resp_t  m1_resp_o,
  output axi_req_t   s_req_o,
  input  axi_resp_t  s_resp_i,
  output logic [1:0] wr_gnt_o,
  output logic [1:0] rd_gnt_o,
  output logic       wd_err_o
);

  localparam logic             WD_EN_C  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LIM_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WD_PRE_C = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  arb_wr_state_e    wr_state_r, wr_state_s;
  arb_rd_state_e    rd_state_r, rd_state_s;
  logic [1:0]       wr_gnt_s, rd_gnt_s;
  logic             wr_own_s, rd_own_s;
  axi_req_t         wr_m_s, rd_m_s;
  logic             wr_adv_s, rd_adv_s, wr_done_s, rd_done_s;
  logic             aw_hs_s, w_last_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic [CNT_W-1:0] wr_cnt_r, rd_cnt_r;
  logic             wr_wd_inc_s, rd_wd_inc_s;
  logic             wd_err_r;

  assign wr_own_s = wr_gnt_s[1];
  assign rd_own_s = rd_gnt_s[1];
  assign wr_m_s   = wr_own_s ? m1_req_i : m0_req_i;
  assign rd_m_s   = rd_own_s ? m1_req_i : m0_req_i;

  assign wr_adv_s    = (wr_state_r == W_IDLE) && (m0_req_i.aw_valid || m1_req_i.aw_valid);
  assign rd_adv_s    = (rd_state_r == R_IDLE) && (m0_req_i.ar_valid || m1_req_i.ar_valid);
  assign aw_hs_s     = (wr_state_r == W_ADDR) && wr_m_s.aw_valid && s_resp_i.aw_ready;
  assign w_last_hs_s = (wr_state_r == W_DATA) && wr_m_s.w_valid && s_resp_i.w_ready && wr_m_s.w.last;
  assign b_hs_s      = (wr_state_r == W_RESP) && s_resp_i.b_valid && wr_m_s.b_ready;
  assign ar_hs_s     = (rd_state_r == R_ADDR) && rd_m_s.ar_valid && s_resp_i.ar_ready;
  assign r_hs_s      = (rd_state_r == R_DATA) && s_resp_i.r_valid && rd_m_s.r_ready;
  assign wr_done_s   = b_hs_s;
  assign rd_done_s   = r_hs_s && s_resp_i.r.last;

  axi_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_req_i.aw_valid, m0_req_i.aw_valid}),
    .advance (wr_adv_s),
    .done    (wr_done_s),
    .gnt     (wr_gnt_s)
  );

  axi_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_req_i.ar_valid, m0_req_i.ar_valid}),
    .advance (rd_adv_s),
    .done    (rd_done_s),
    .gnt     (rd_gnt_s)
  );

  // Write FSM next state.
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      W_IDLE:  if (wr_adv_s)    wr_state_s = W_ADDR; else wr_state_s = W_IDLE;
      W_ADDR:  if (aw_hs_s)     wr_state_s = W_DATA; else wr_state_s = W_ADDR;
      W_DATA:  if (w_last_hs_s) wr_state_s = W_RESP; else wr_state_s = W_DATA;
      W_RESP:  if (b_hs_s)      wr_state_s = W_IDLE; else wr_state_s = W_RESP;
      default: wr_state_s = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      R_IDLE:  if (rd_adv_s)  rd_state_s = R_ADDR; else rd_state_s = R_IDLE;
      R_ADDR:  if (ar_hs_s)   rd_state_s = R_DATA; else rd_state_s = R_ADDR;
      R_DATA:  if (rd_done_s) rd_state_s = R_IDLE; else rd_state_s = R_DATA;
      default: rd_state_s = R_IDLE;
    endcase
  end

  // State registers for both channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      rd_state_r <= R_IDLE;
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
    end
  end

  // Channel steering: only the active phase of each path reaches the owner.
  always_comb begin
    s_req_o   = '0;
    m0_resp_o = '0;
    m1_resp_o = '0;
    case (wr_state_r)
      W_ADDR: begin
        s_req_o.aw       = wr_m_s.aw;
        s_req_o.aw_valid = wr_m_s.aw_valid;
        if (wr_own_s) m1_resp_o.aw_ready = s_resp_i.aw_ready;
        else          m0_resp_o.aw_ready = s_resp_i.aw_ready;
      end
      W_DATA: begin
        s_req_o.w       = wr_m_s.w;
        s_req_o.w_valid = wr_m_s.w_valid;
        if (wr_own_s) m1_resp_o.w_ready = s_resp_i.w_ready;
        else          m0_resp_o.w_ready = s_resp_i.w_ready;
      end
      W_RESP: begin
        s_req_o.b_ready = wr_m_s.b_ready;
        if (wr_own_s) begin
          m1_resp_o.b       = s_resp_i.b;
          m1_resp_o.b_valid = s_resp_i.b_valid;
        end else begin
          m0_resp_o.b       = s_resp_i.b;
          m0_resp_o.b_valid = s_resp_i.b_valid;
        end
      end
      default: begin
      end
    endcase
    case (rd_state_r)
      R_ADDR: begin
        s_req_o.ar       = rd_m_s.ar;
        s_req_o.ar_valid = rd_m_s.ar_valid;
        if (rd_own_s) m1_resp_o.ar_ready = s_resp_i.ar_ready;
        else          m0_resp_o.ar_ready = s_resp_i.ar_ready;
      end
      R_DATA: begin
        s_req_o.r_ready = rd_m_s.r_ready;
        if (rd_own_s) begin
          m1_resp_o.r       = s_resp_i.r;
          m1_resp_o.r_valid = s_resp_i.r_valid;
        end else begin
          m0_resp_o.r       = s_resp_i.r;
          m0_resp_o.r_valid = s_resp_i.r_valid;
        end
      end
      default: begin
      end
    endcase
  end

  // Watchdog counts only while the slave owes a response; it saturates at the limit.
  assign wr_wd_inc_s = WD_EN_C && (wr_state_r == W_RESP) && !s_resp_i.b_valid && (wr_cnt_r != WD_LIM_C);
  assign rd_wd_inc_s = WD_EN_C && (rd_state_r == R_DATA) && !s_resp_i.r_valid && (rd_cnt_r != WD_LIM_C);

  // Per-channel wait counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_r <= '0;
      rd_cnt_r <= '0;
    end else begin
      if (w_last_hs_s || b_hs_s) wr_cnt_r <= '0;
      else if (wr_wd_inc_s)      wr_cnt_r <= wr_cnt_r + ONE_C;
      if (ar_hs_s || r_hs_s)     rd_cnt_r <= '0;
      else if (rd_wd_inc_s)      rd_cnt_r <= rd_cnt_r + ONE_C;
    end
  end

  // Sticky error, set on the edge where either counter reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_err_r <= 1'b0;
    end else if ((wr_wd_inc_s && (wr_cnt_r == WD_PRE_C)) || (rd_wd_inc_s && (rd_cnt_r == WD_PRE_C))) begin
      wd_err_r <= 1'b1;
    end
  end

  assign wr_gnt_o = wr_gnt_s;
  assign rd_gnt_o = rd_gnt_s;
  assign wd_err_o = wd_err_r;

endmodule

// File: tb/tb_axi_2to1_arbiter.sv
// Directed bench for axi_2to1_arbiter: a table of per-cycle write-channel
// vectors plus hand-written sequences for overlap, early W, watchdog and reset.
module tb_axi_2to1_arbiter;
  import axi_2to1_arbiter_pkg::*;

  localparam logic [31:0] A0 = 32'h1100_0000;
  localparam logic [31:0] A1 = 32'h1300_0000;

  logic       clk = 1'b0;
  logic       rst;
  axi_req_t   m0_req, m1_req, s_req;
  axi_resp_t  m0_resp, m1_resp, s_resp;
  logic [1:0] wr_gnt, rd_gnt;
  logic       wd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_2to1_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req_i  (m0_req),
    .m0_resp_o (m0_resp),
    .m1_req_i  (m1_req),
    .m1_resp_o (m1_resp),
    .s_req_o   (s_req),
    .s_resp_i  (s_resp),
    .wr_gnt_o  (wr_gnt),
    .rd_gnt_o  (rd_gnt),
    .wd_err_o  (wd_err)
  );

  typedef struct packed {
    logic        do_rst;
    logic [1:0]  aw_v, w_v, b_rdy;
    logic        s_aw_rdy, s_w_rdy, s_b_v;
    logic        e_s_aw_v, e_s_w_v, e_s_b_rdy;
    logic [31:0] e_addr;
    logic [1:0]  e_aw_rdy, e_w_rdy, e_b_v, e_gnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] awv, input logic [1:0] wv,
                              input logic [1:0] brdy, input logic sa, input logic sw, input logic sb,
                              input logic ea, input logic ew, input logic eb, input logic [31:0] addr,
                              input logic [1:0] ear, input logic [1:0] ewr, input logic [1:0] ebv,
                              input logic [1:0] egnt);
    vec_t v;
    v.do_rst = r;  v.aw_v = awv; v.w_v = wv; v.b_rdy = brdy;
    v.s_aw_rdy = sa; v.s_w_rdy = sw; v.s_b_v = sb;
    v.e_s_aw_v = ea; v.e_s_w_v = ew; v.e_s_b_rdy = eb; v.e_addr = addr;
    v.e_aw_rdy = ear; v.e_w_rdy = ewr; v.e_b_v = ebv; v.e_gnt = egnt;
    return v;
  endfunction

  task automatic init_inputs();
    m0_req = '0;
    m1_req = '0;
    s_resp = '0;
    m0_req.aw.addr  = A0;
    m0_req.aw.size  = 3'd6;
    m0_req.aw.burst = 2'b01;
    m0_req.w.data   = {8{64'h0D0D_0000_0000_0A00}};
    m0_req.w.strb   = '1;
    m0_req.w.last   = 1'b1;
    m1_req.aw.addr  = A1;
    m1_req.aw.size  = 3'd6;
    m1_req.aw.burst = 2'b01;
    m1_req.w.data   = {8{64'hB1B1_0000_0000_0B00}};
    m1_req.w.strb   = '1;
    m1_req.w.last   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    init_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [511:0] pat;

  initial begin
    rst = 1'b1;
    init_inputs();
    repeat (2) @(negedge clk);
    #2;
    chk("rst wr_gnt", wr_gnt, 2'b00);
    chk("rst rd_gnt", rd_gnt, 2'b00);
    chk("rst wd_err", wd_err, 1'b0);
    chk("rst s_valids", {s_req.aw_valid, s_req.w_valid, s_req.b_ready, s_req.ar_valid, s_req.r_ready}, 5'b0);
    chk("rst m_readies", {m0_resp.aw_ready, m0_resp.w_ready, m1_resp.aw_ready, m1_resp.w_ready}, 4'b0);
    rst = 1'b0;

    // T1: m0 single-beat write
    vecs.push_back(mk(1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0,    2'b01, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 2'b00, 2'b01, 2'b01));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00));
    // T2: simultaneous AW after fresh reset, m0 re-requests so the pointer decides
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0,    2'b00, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0,    2'b01, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(1'b0, 2'b10, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01));
    vecs.push_back(mk(1'b0, 2'b10, 2'b10, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 2'b00, 2'b01, 2'b01));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A1,    2'b10, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk(1'b0, 2'b01, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b10, 2'b00, 2'b10));
    vecs.push_back(mk(1'b0, 2'b01, 2'b01, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 2'b00, 2'b10, 2'b10));
    vecs.push_back(mk(1'b0, 2'b01, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b01, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0,    2'b00, 2'b00, 2'b00, 2'b01));

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      @(negedge clk);
      m0_req.aw_valid   = vecs[i].aw_v[0];
      m1_req.aw_valid   = vecs[i].aw_v[1];
      m0_req.w_valid    = vecs[i].w_v[0];
      m1_req.w_valid    = vecs[i].w_v[1];
      m0_req.b_ready    = vecs[i].b_rdy[0];
      m1_req.b_ready    = vecs[i].b_rdy[1];
      s_resp.aw_ready   = vecs[i].s_aw_rdy;
      s_resp.w_ready    = vecs[i].s_w_rdy;
      s_resp.b_valid    = vecs[i].s_b_v;
      #2;
      chk($sformatf("v%0d s_aw_valid", i), s_req.aw_valid, vecs[i].e_s_aw_v);
      chk($sformatf("v%0d s_aw_addr", i), s_req.aw.addr, vecs[i].e_addr);
      chk($sformatf("v%0d s_w_valid", i), s_req.w_valid, vecs[i].e_s_w_v);
      chk($sformatf("v%0d s_b_ready", i), s_req.b_ready, vecs[i].e_s_b_rdy);
      chk($sformatf("v%0d aw_ready", i), {m1_resp.aw_ready, m0_resp.aw_ready}, vecs[i].e_aw_rdy);
      chk($sformatf("v%0d w_ready", i), {m1_resp.w_ready, m0_resp.w_ready}, vecs[i].e_w_rdy);
      chk($sformatf("v%0d b_valid", i), {m1_resp.b_valid, m0_resp.b_valid}, vecs[i].e_b_v);
      chk($sformatf("v%0d wr_gnt", i), wr_gnt, vecs[i].e_gnt);
    end

    // T3: m0 write overlapped with m1 4-beat read
    do_reset();
    m0_req.aw.addr  = 32'h1200_0000;
    m0_req.aw_valid = 1'b1;
    m0_req.w_valid  = 1'b1;
    m0_req.b_ready  = 1'b1;
    m1_req.ar.addr  = 32'h1100_0000;
    m1_req.ar.len   = 8'd3;
    m1_req.ar_valid = 1'b1;
    m1_req.r_ready  = 1'b1;
    s_resp.aw_ready = 1'b1;
    s_resp.w_ready  = 1'b1;
    s_resp.ar_ready = 1'b1;
    #2;
    chk("t3 bubble gnts", {wr_gnt, rd_gnt}, 4'b0000);
    @(negedge clk); #2;
    chk("t3 s_aw_valid", s_req.aw_valid, 1'b1);
    chk("t3 s_aw_addr", s_req.aw.addr, 32'h1200_0000);
    chk("t3 s_ar_valid", s_req.ar_valid, 1'b1);
    chk("t3 s_ar_addr", s_req.ar.addr, 32'h1100_0000);
    chk("t3 gnts", {wr_gnt, rd_gnt}, 4'b0110);
    @(negedge clk);
    m0_req.aw_valid = 1'b0;
    m1_req.ar_valid = 1'b0;
    s_resp.r_valid  = 1'b1;
    s_resp.r.data   = 512'd0;
    s_resp.r.last   = 1'b0;
    #2;
    chk("t3 s_w_valid", s_req.w_valid, 1'b1);
    chk("t3 beat0 m1 r_valid", m1_resp.r_valid, 1'b1);
    chk("t3 beat0 m1 last", m1_resp.r.last, 1'b0);
    chk("t3 beat0 m0 r_valid", m0_resp.r_valid, 1'b0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      m0_req.w_valid = 1'b0;
      s_resp.b_valid = (k == 1);
      s_resp.r.data  = 512'(k);
      s_resp.r.last  = (k == 3);
      #2;
      chk($sformatf("t3 beat%0d m1 r_valid", k), m1_resp.r_valid, 1'b1);
      chk($sformatf("t3 beat%0d m1 last", k), m1_resp.r.last, (k == 3));
      chk($sformatf("t3 beat%0d m1 data", k), m1_resp.r.data[63:0], 64'(k));
      chk($sformatf("t3 beat%0d m0 r_valid", k), m0_resp.r_valid, 1'b0);
      chk($sformatf("t3 beat%0d rd_gnt", k), rd_gnt, 2'b10);
      if (k == 1) chk("t3 m0 b_valid", m0_resp.b_valid, 1'b1);
      else        chk($sformatf("t3 beat%0d wr_gnt", k), wr_gnt, 2'b00);
    end
    @(negedge clk);
    s_resp.r_valid = 1'b0;
    #2;
    chk("t3 end rd_gnt", rd_gnt, 2'b00);

    // T4: m1 presents W before AW
    @(negedge clk);
    init_inputs();
    pat = {64'hFEED_0000_0000_00FF, {6{64'h0123_4567_89AB_CDEF}}, 64'hC0DE_0000_0000_0001};
    m1_req.w.data  = pat;
    m1_req.w_valid = 1'b1;
    m1_req.b_ready = 1'b1;
    s_resp.w_ready = 1'b1;
    #2;
    chk("t4 early w_ready", m1_resp.w_ready, 1'b0);
    chk("t4 early s_w_valid", s_req.w_valid, 1'b0);
    @(negedge clk);
    m1_req.aw_valid = 1'b1;
    #2;
    chk("t4 idle w_ready", m1_resp.w_ready, 1'b0);
    @(negedge clk); #2;
    chk("t4 addr w_ready", m1_resp.w_ready, 1'b0);
    chk("t4 addr aw_ready", m1_resp.aw_ready, 1'b0);
    chk("t4 wr_gnt", wr_gnt, 2'b10);
    @(negedge clk);
    s_resp.aw_ready = 1'b1;
    #2;
    chk("t4 hs aw_ready", m1_resp.aw_ready, 1'b1);
    chk("t4 hs w_ready", m1_resp.w_ready, 1'b0);
    @(negedge clk);
    m1_req.aw_valid = 1'b0;
    #2;
    chk("t4 data w_ready", m1_resp.w_ready, 1'b1);
    chk("t4 data lo", s_req.w.data[63:0], 64'hC0DE_0000_0000_0001);
    chk("t4 data hi", s_req.w.data[511:448], 64'hFEED_0000_0000_00FF);
    chk("t4 strb", s_req.w.strb, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4 m0 w_ready", m0_resp.w_ready, 1'b0);
    @(negedge clk);
    m1_req.w_valid = 1'b0;
    s_resp.b_valid = 1'b1;
    s_resp.b.id    = 4'h5;
    #2;
    chk("t4 m1 b_valid", m1_resp.b_valid, 1'b1);
    chk("t4 m1 b_id", m1_resp.b.id, 4'h5);
    chk("t4 m0 b_valid", m0_resp.b_valid, 1'b0);
    @(negedge clk);
    s_resp.b_valid = 1'b0;
    #2;
    chk("t4 end wr_gnt", wr_gnt, 2'b00);

    // T5: withheld B trips the watchdog after 16 waiting cycles
    @(negedge clk);
    init_inputs();
    m0_req.aw_valid = 1'b1;
    m0_req.w_valid  = 1'b1;
    m0_req.b_ready  = 1'b1;
    s_resp.aw_ready = 1'b1;
    s_resp.w_ready  = 1'b1;
    #2;
    chk("t5 start wd_err", wd_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    m0_req.aw_valid = 1'b0;
    @(negedge clk);
    m0_req.w_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t5 wd_err at 15", wd_err, 1'b0);
    chk("t5 wr_gnt waiting", wr_gnt, 2'b01);
    @(posedge clk);
    #1;
    chk("t5 wd_err at 16", wd_err, 1'b1);
    repeat (3) @(negedge clk);
    s_resp.b_valid = 1'b1;
    #2;
    chk("t5 m0 b_valid", m0_resp.b_valid, 1'b1);
    @(negedge clk);
    s_resp.b_valid = 1'b0;
    #2;
    chk("t5 end wr_gnt", wr_gnt, 2'b00);
    chk("t5 sticky wd_err", wd_err, 1'b1);

    // T6: reset in the middle of a 4-beat read
    @(negedge clk);
    init_inputs();
    m1_req.ar.len   = 8'd3;
    m1_req.ar_valid = 1'b1;
    m1_req.r_ready  = 1'b1;
    s_resp.ar_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m1_req.ar_valid = 1'b0;
    s_resp.r_valid  = 1'b1;
    @(negedge clk);
    s_resp.r.data = 512'd1;
    #2;
    chk("t6 beat1 rd_gnt", rd_gnt, 2'b10);
    @(negedge clk);
    s_resp.r.data = 512'd2;
    rst = 1'b1;
    #2;
    chk("t6 rst rd_gnt", rd_gnt, 2'b00);
    chk("t6 rst m1 r_valid", m1_resp.r_valid, 1'b0);
    chk("t6 rst s_r_ready", s_req.r_ready, 1'b0);
    chk("t6 rst s_ar_valid", s_req.ar_valid, 1'b0);
    chk("t6 rst wd_err", wd_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    init_inputs();
    m0_req.ar.addr  = 32'h1100_0040;
    m0_req.ar_valid = 1'b1;
    m0_req.r_ready  = 1'b1;
    s_resp.ar_ready = 1'b1;
    #2;
    chk("t6 new idle rd_gnt", rd_gnt, 2'b00);
    @(negedge clk); #2;
    chk("t6 new rd_gnt", rd_gnt, 2'b01);
    chk("t6 new ar_addr", s_req.ar.addr, 32'h1100_0040);
    chk("t6 new ar_ready", m0_resp.ar_ready, 1'b1);
    @(negedge clk);
    m0_req.ar_valid = 1'b0;
    s_resp.r_valid  = 1'b1;
    s_resp.r.last   = 1'b1;
    #2;
    chk("t6 new m0 r_valid", m0_resp.r_valid, 1'b1);
    chk("t6 new m0 last", m0_resp.r.last, 1'b1);
    chk("t6 new m1 r_valid", m1_resp.r_valid, 1'b0);
    @(negedge clk);
    s_resp.r_valid = 1'b0;
    #2;
    chk("t6 end rd_gnt", rd_gnt, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
